reg_bus_sched: RTL and testbench

- Sequencer and arbiter for a bank of NUM_REGS 8-bit tristate registers that share one internal data bus.
- Each register has a per-register output enable (drives the bus) and a write enable (captures the bus on the rising clock edge).
- Accepts register-to-register move requests from NUM_REQ requesters and grants them round-robin.
- Drives the bank's out_en/write_en lines so that at most one register ever drives the bus.

---
 rtl/reg_bus_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 29 ++
 rtl/reg_bus_sched.sv | 165 ++++++++++++++++
 tb/tb_reg_bus_sched.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_bus_pkg.sv
// Shared state encoding and counter widths for the register-bus sequencer.
package reg_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DRIVE = 3'd1,
    ST_LATCH = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } state_e;

  localparam int unsigned XFER_CNT_W = 16;
  localparam int unsigned ERR_CNT_W  = 8;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester at or after 'pointer'.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   pointer,
  output logic [NUM_REQ-1:0] winner,
  output logic               valid
);

  always_comb begin
    logic [PTR_W-1:0] idx;
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    if (en) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        idx = PTR_W'((32'(pointer) + i) % NUM_REQ);
        if (!valid && req[idx]) begin
          winner[idx] = 1'b1;
          valid       = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/reg_bus_sched.sv
// Move sequencer/arbiter for a shared-bus register bank; enables are registered one-hot.
// Optional REG_BUS_XFER_CNT_EN adds transfer and error counters.
module reg_bus_sched
  import reg_bus_pkg::*;
#(
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned NUM_REQ  = 2,
  parameter int unsigned IDX_W    = $clog2(NUM_REGS)
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*IDX_W-1:0] req_src,
  input  logic [NUM_REQ*IDX_W-1:0] req_dst,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       done,
  output logic [NUM_REQ-1:0]       err,
  output logic [NUM_REGS-1:0]      out_en,
  output logic [NUM_REGS-1:0]      write_en,
`ifdef REG_BUS_XFER_CNT_EN
  output logic [XFER_CNT_W-1:0]    xfer_cnt,
  output logic [ERR_CNT_W-1:0]     err_cnt,
`endif
  output logic                     busy
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e               state_q, state_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d, win_q, win_d, win_idx, arb_ptr;
  logic [IDX_W-1:0]     src_q, src_d, dst_q, dst_d, sel_src, sel_dst;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d, done_q, done_d, err_q, err_d, arb_win;
  logic [NUM_REGS-1:0]  out_en_q, out_en_d, write_en_q, write_en_d;
  logic                 arb_valid, legal;

  // Pointer holds the last winner; search starts one past it.
  assign arb_ptr = PTR_W'((32'(ptr_q) + 32'd1) % NUM_REQ);

  rr_arbiter #(
    .NUM_REQ(NUM_REQ),
    .PTR_W  (PTR_W)
  ) u_arb (
    .en     (state_q == ST_IDLE),
    .req    (req),
    .pointer(arb_ptr),
    .winner (arb_win),
    .valid  (arb_valid)
  );

  always_comb begin
    win_idx = '0;
    sel_src = '0;
    sel_dst = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (arb_win[i]) begin
        win_idx = PTR_W'(i);
        sel_src = req_src[i*IDX_W +: IDX_W];
        sel_dst = req_dst[i*IDX_W +: IDX_W];
      end
    end
    legal = (32'(sel_src) < NUM_REGS) && (32'(sel_dst) < NUM_REGS) && (sel_src != sel_dst);
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    win_d      = win_q;
    src_d      = src_q;
    dst_d      = dst_q;
    gnt_d      = '0;
    done_d     = '0;
    err_d      = '0;
    out_en_d   = '0;
    write_en_d = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          ptr_d = win_idx;
          win_d = win_idx;
          src_d = sel_src;
          dst_d = sel_dst;
          if (legal) begin
            state_d  = ST_DRIVE;
            gnt_d    = arb_win;
            out_en_d = NUM_REGS'(1) << sel_src;
          end else begin
            state_d = ST_ERR;
            err_d   = arb_win;
          end
        end
      end
      ST_DRIVE: begin
        state_d    = ST_LATCH;
        out_en_d   = NUM_REGS'(1) << src_q;
        write_en_d = NUM_REGS'(1) << dst_q;
      end
      ST_LATCH: begin
        state_d = ST_DONE;
        done_d  = NUM_REQ'(1) << win_q;
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      ptr_q      <= PTR_W'(NUM_REQ - 1);
      win_q      <= '0;
      src_q      <= '0;
      dst_q      <= '0;
      gnt_q      <= '0;
      done_q     <= '0;
      err_q      <= '0;
      out_en_q   <= '0;
      write_en_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      win_q      <= win_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      err_q      <= err_d;
      out_en_q   <= out_en_d;
      write_en_q <= write_en_d;
    end
  end

  assign gnt      = gnt_q;
  assign done     = done_q;
  assign err      = err_q;
  assign out_en   = out_en_q;
  assign write_en = write_en_q;
  assign busy     = (state_q != ST_IDLE);

`ifdef REG_BUS_XFER_CNT_EN
  logic [XFER_CNT_W-1:0] xfer_cnt_q, xfer_cnt_d;
  logic [ERR_CNT_W-1:0]  err_cnt_q, err_cnt_d;

  always_comb begin
    xfer_cnt_d = xfer_cnt_q;
    err_cnt_d  = err_cnt_q;
    if (state_q == ST_DONE) xfer_cnt_d = xfer_cnt_q + 1'b1;
    if (state_q == ST_ERR && err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      xfer_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      xfer_cnt_q <= xfer_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign xfer_cnt = xfer_cnt_q;
  assign err_cnt  = err_cnt_q;
`endif

endmodule

// File: tb/tb_reg_bus_sched.sv
// Directed bench for reg_bus_sched with a behavioural model of the tristate register bank.
module tb_reg_bus_sched;

  localparam int unsigned NR = 8;
  localparam int unsigned NQ = 2;
  localparam int unsigned IW = 3;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic               reset_n;
  logic [NQ-1:0]      req, gnt, done, err;
  logic [NQ*IW-1:0]   req_src, req_dst;
  logic [NR-1:0]      out_en, write_en;
  logic               busy;

  logic [NQ-1:0]      req6, gnt6, done6, err6;
  logic [NQ*IW-1:0]   src6, dst6;
  logic [5:0]         out_en6, write_en6;
  logic               busy6;

`ifdef REG_BUS_XFER_CNT_EN
  logic [15:0] xfer_cnt, xfer_cnt6, exp_xfer;
  logic [7:0]  err_cnt, err_cnt6, exp_err;
`endif

  reg_bus_sched #(.NUM_REGS(NR), .NUM_REQ(NQ)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .req     (req),
    .req_src (req_src),
    .req_dst (req_dst),
    .gnt     (gnt),
    .done    (done),
    .err     (err),
    .out_en  (out_en),
    .write_en(write_en),
`ifdef REG_BUS_XFER_CNT_EN
    .xfer_cnt(xfer_cnt),
    .err_cnt (err_cnt),
`endif
    .busy    (busy)
  );

  reg_bus_sched #(.NUM_REGS(6), .NUM_REQ(NQ)) dut6 (
    .clock   (clock),
    .reset_n (reset_n),
    .req     (req6),
    .req_src (src6),
    .req_dst (dst6),
    .gnt     (gnt6),
    .done    (done6),
    .err     (err6),
    .out_en  (out_en6),
    .write_en(write_en6),
`ifdef REG_BUS_XFER_CNT_EN
    .xfer_cnt(xfer_cnt6),
    .err_cnt (err_cnt6),
`endif
    .busy    (busy6)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Register bank model: bus carries the enabled register, capture on rising edge.
  logic [7:0] bank [NR];
  logic [7:0] exp_regs [NR];
  logic [7:0] bus;
  logic       load;

  always_comb begin
    bus = '0;
    for (int i = 0; i < NR; i++) if (out_en[i]) bus = bus | bank[i];
  end

  always @(posedge clock) begin
    for (int i = 0; i < NR; i++) begin
      if (load) bank[i] <= 8'(160 + i);
      else if (write_en[i]) bank[i] <= bus;
    end
  end

  always @(negedge clock) begin
    if (reset_n) begin
      chk("onehot0_out_en", 32'($onehot0(out_en)), 32'd1);
      chk("onehot0_write_en", 32'($onehot0(write_en)), 32'd1);
      chk("write_without_drive", 32'(|write_en && !(|out_en)), 32'd0);
      chk("onehot0_out_en6", 32'($onehot0(out_en6)), 32'd1);
    end
  end

  typedef struct {
    logic [1:0] rq;
    logic [2:0] s0, d0, s1, d1;
    int         w;
    bit         bad;
  } vec_t;

  vec_t vecs [8];

  // Called at a falling edge with the DUT idle; returns at a falling edge with it idle again.
  task automatic run_vec(input vec_t v, input int n);
    logic [2:0] s, d;
    logic [1:0] oh;
    s  = (v.w == 0) ? v.s0 : v.s1;
    d  = (v.w == 0) ? v.d0 : v.d1;
    oh = (v.w == 0) ? 2'b01 : 2'b10;
    req     = v.rq;
    req_src = {v.s1, v.s0};
    req_dst = {v.d1, v.d0};
    @(negedge clock);
    if (!v.bad) begin
      chk($sformatf("v%0d_gnt", n), 32'(gnt), 32'(oh));
      chk($sformatf("v%0d_drive_out_en", n), 32'(out_en), 32'(1) << s);
      chk($sformatf("v%0d_drive_write_en", n), 32'(write_en), 32'd0);
      chk($sformatf("v%0d_busy", n), 32'(busy), 32'd1);
      req = '0;
      @(negedge clock);
      chk($sformatf("v%0d_latch_gnt", n), 32'(gnt), 32'd0);
      chk($sformatf("v%0d_latch_out_en", n), 32'(out_en), 32'(1) << s);
      chk($sformatf("v%0d_latch_write_en", n), 32'(write_en), 32'(1) << d);
      @(negedge clock);
      chk($sformatf("v%0d_done", n), 32'(done), 32'(oh));
      chk($sformatf("v%0d_done_enables", n), 32'(out_en | write_en), 32'd0);
      chk($sformatf("v%0d_data", n), 32'(bank[d]), 32'(exp_regs[s]));
      exp_regs[d] = exp_regs[s];
`ifdef REG_BUS_XFER_CNT_EN
      exp_xfer = exp_xfer + 16'd1;
`endif
      @(negedge clock);
      chk($sformatf("v%0d_idle_busy", n), 32'(busy), 32'd0);
      chk($sformatf("v%0d_idle_done", n), 32'(done), 32'd0);
    end else begin
      chk($sformatf("v%0d_err", n), 32'(err), 32'(oh));
      chk($sformatf("v%0d_err_gnt", n), 32'(gnt), 32'd0);
      chk($sformatf("v%0d_err_enables", n), 32'(out_en | write_en), 32'd0);
      req = '0;
      @(negedge clock);
      chk($sformatf("v%0d_err_idle", n), 32'({busy, err, done}), 32'd0);
`ifdef REG_BUS_XFER_CNT_EN
      exp_err = exp_err + 8'd1;
`endif
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{2'b01, 3'd2, 3'd5, 3'd0, 3'd0, 0, 1'b0};
    vecs[1] = '{2'b11, 3'd1, 3'd3, 3'd4, 3'd6, 1, 1'b0};
    vecs[2] = '{2'b11, 3'd1, 3'd3, 3'd4, 3'd6, 0, 1'b0};
    vecs[3] = '{2'b10, 3'd0, 3'd0, 3'd3, 3'd3, 1, 1'b1};
    vecs[4] = '{2'b01, 3'd7, 3'd0, 3'd0, 3'd0, 0, 1'b0};
    vecs[5] = '{2'b11, 3'd0, 3'd7, 3'd6, 3'd1, 1, 1'b0};
    vecs[6] = '{2'b10, 3'd0, 3'd0, 3'd5, 3'd2, 1, 1'b0};
    vecs[7] = '{2'b11, 3'd3, 3'd3, 3'd2, 3'd4, 0, 1'b1};
    for (int i = 0; i < NR; i++) exp_regs[i] = 8'(160 + i);
`ifdef REG_BUS_XFER_CNT_EN
    exp_xfer = '0;
    exp_err  = '0;
`endif
    reset_n = 1'b0;
    load    = 1'b1;
    req = '0; req_src = '0; req_dst = '0;
    req6 = '0; src6 = '0; dst6 = '0;
    repeat (2) @(negedge clock);
    chk("reset_outputs", 32'({gnt, done, err}), 32'd0);
    chk("reset_enables", 32'(out_en | write_en), 32'd0);
    chk("reset_busy", 32'({busy, busy6}), 32'd0);
    load    = 1'b0;
    reset_n = 1'b1;
    @(negedge clock);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Source/destination changes after capture must not reach the enables.
    req = 2'b01; req_src = {3'd0, 3'd4}; req_dst = {3'd0, 3'd1};
    @(negedge clock);
    chk("stab_gnt", 32'(gnt), 32'h1);
    chk("stab_drive_out_en", 32'(out_en), 32'h10);
    req = '0; req_src = {3'd0, 3'd6}; req_dst = {3'd0, 3'd0};
    @(negedge clock);
    chk("stab_latch_out_en", 32'(out_en), 32'h10);
    chk("stab_latch_write_en", 32'(write_en), 32'h02);
    @(negedge clock);
    chk("stab_done", 32'(done), 32'h1);
    chk("stab_data", 32'(bank[1]), 32'(exp_regs[4]));
    exp_regs[1] = exp_regs[4];
    @(negedge clock);

    // Reset asserted while in LATCH: enables drop at once and no write lands.
    req = 2'b01; req_src = {3'd0, 3'd1}; req_dst = {3'd0, 3'd2};
    @(negedge clock);
    chk("rst_gnt", 32'(gnt), 32'h1);
    req = '0;
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_enables", 32'(out_en | write_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(posedge clock);
    #1 chk("rst_no_write", 32'(bank[2]), 32'(exp_regs[2]));
    @(negedge clock);
    reset_n = 1'b1;
`ifdef REG_BUS_XFER_CNT_EN
    exp_xfer = '0;
    exp_err  = '0;
`endif

    // Continuous contention right after reset: 0 first, then alternate, 4 cycles apart.
    req = 2'b11; req_src = {3'd2, 3'd0}; req_dst = {3'd3, 3'd1};
    for (int c = 1; c <= 16; c++) begin
      logic [1:0] eg;
      @(negedge clock);
      eg = (c % 4 != 1) ? 2'b00 : (((c / 4) % 2 == 0) ? 2'b01 : 2'b10);
      chk($sformatf("cont_gnt_c%0d", c), 32'(gnt), 32'(eg));
      if (c == 3 || c == 11) chk($sformatf("cont_data_c%0d", c), 32'(bank[1]), 32'(exp_regs[0]));
      if (c == 7 || c == 15) chk($sformatf("cont_data_c%0d", c), 32'(bank[3]), 32'(exp_regs[2]));
      if (c == 13) req = '0;
    end
    exp_regs[1] = exp_regs[0];
    exp_regs[3] = exp_regs[2];
`ifdef REG_BUS_XFER_CNT_EN
    exp_xfer = exp_xfer + 16'd4;
`endif
    chk("cont_idle", 32'(busy), 32'd0);

    // Six-register instance: index 7 is out of range, then a legal move.
    req6 = 2'b01; src6 = {3'd0, 3'd7}; dst6 = {3'd0, 3'd0};
    @(negedge clock);
    chk("n6_err", 32'(err6), 32'h1);
    chk("n6_err_quiet", 32'({gnt6, out_en6, write_en6}), 32'd0);
    req6 = '0;
    @(negedge clock);
    chk("n6_err_idle", 32'({busy6, done6}), 32'd0);
    req6 = 2'b01; src6 = {3'd0, 3'd5}; dst6 = {3'd0, 3'd0};
    @(negedge clock);
    chk("n6_gnt", 32'(gnt6), 32'h1);
    chk("n6_drive_out_en", 32'(out_en6), 32'h20);
    req6 = '0;
    @(negedge clock);
    chk("n6_latch", 32'({out_en6, write_en6}), 32'({6'h20, 6'h01}));
    @(negedge clock);
    chk("n6_done", 32'(done6), 32'h1);
    @(negedge clock);

`ifdef REG_BUS_XFER_CNT_EN
    chk("cnt_xfer", 32'(xfer_cnt), 32'(exp_xfer));
    chk("cnt_err", 32'(err_cnt), 32'(exp_err));
    chk("cnt6", 32'({xfer_cnt6, err_cnt6}), 32'({16'd1, 8'd1}));
    force dut.xfer_cnt_q = 16'hFFFF;
    @(negedge clock);
    release dut.xfer_cnt_q;
    chk("cnt_preload", 32'(xfer_cnt), 32'hFFFF);
    exp_xfer = 16'hFFFF;
    run_vec(vecs[0], 99);
    chk("cnt_wrap", 32'(xfer_cnt), 32'(exp_xfer));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
